// File: rtl/sequential_regdec_ctrl_if.sv
// Bundle between the shift-stage controller and its requester / downstream shift stage.
// dbg_state mirrors the controller FSM for observation only.
interface sequential_regdec_ctrl_if;
  logic       start;
  logic [7:0] data_in;
  logic [2:0] shift_count;
  logic [7:0] stage_out;
  logic [2:0] sequenceur;
  logic [7:0] stage_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [1:0] dbg_state;

  modport master (
    output start, data_in, shift_count, stage_out,
    input  sequenceur, stage_in, busy, done, result, dbg_state
  );

  modport slave (
    input  start, data_in, shift_count, stage_out,
    output sequenceur, stage_in, busy, done, result, dbg_state
  );
endinterface

// File: rtl/sequential_regdec_ctrl.sv
// Drives the left-shift stage through load, step 1..N, capture, and returns the
// captured stage byte in result with a one-cycle done pulse.
module sequential_regdec_ctrl (
  input  logic                     clk,
  input  logic                     reset,
  sequential_regdec_ctrl_if.slave  bus
);

  // Handshake: start is taken on an edge only in IDLE (busy=0); busy stays high from
  // that edge until the capture edge, which also raises done for exactly one cycle.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_STEP    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0] state_q,      state_d;
  logic [2:0] target_q,     target_d;
  logic [2:0] sequenceur_q, sequenceur_d;
  logic [7:0] stage_in_q,   stage_in_d;
  logic [7:0] result_q,     result_d;
  logic       busy_q,       busy_d;
  logic       done_q,       done_d;

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    sequenceur_d = sequenceur_q;
    stage_in_d   = stage_in_q;
    result_d     = result_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d       = 1'b0;
        sequenceur_d = 3'd0;
        if (bus.start) begin
          stage_in_d = bus.data_in;
          target_d   = bus.shift_count;
          busy_d     = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (target_q == 3'd0) begin
          state_d = S_CAPTURE;
        end else begin
          sequenceur_d = 3'd1;
          state_d      = S_STEP;
        end
      end
      S_STEP: begin
        // target never exceeds 7, so the increment cannot wrap before the match.
        if (sequenceur_q == target_q) begin
          state_d = S_CAPTURE;
        end else begin
          sequenceur_d = sequenceur_q + 3'd1;
        end
      end
      S_CAPTURE: begin
        result_d     = bus.stage_out;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        sequenceur_d = 3'd0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      target_q     <= 3'd0;
      sequenceur_q <= 3'd0;
      stage_in_q   <= 8'h00;
      result_q     <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      sequenceur_q <= sequenceur_d;
      stage_in_q   <= stage_in_d;
      result_q     <= result_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.sequenceur = sequenceur_q;
  assign bus.stage_in   = stage_in_q;
  assign bus.result     = result_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.dbg_state  = state_q;

endmodule
